// File: rtl/rx_link_pkg.sv
// Shared link-layer constants: FSM state encoding and the 8b control symbols
// also used by the transmit side.
package rx_link_pkg;

   localparam logic [7:0] COM_SYM = 8'hBC;
   localparam logic [7:0] IDL_SYM = 8'h7C;

   typedef enum logic [2:0] {
      ST_DISABLED = 3'd0,
      ST_SEARCH   = 3'd1,
      ST_LOCKING  = 3'd2,
      ST_ACTIVE   = 3'd3,
      ST_RECOVER  = 3'd4
   } state_e;

endpackage

// File: rtl/rx_link_ctrl_if.sv
// Byte-stream bundle between deserializer, link controller and payload sink.
// The master side drives received bytes; the slave side returns realign and payload.
interface rx_link_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic       rx_err;
   logic       deser_realign;
   logic       valid_out;
   logic [7:0] data_out;

   modport master (
      output rx_data, rx_strobe, rx_err,
      input  deser_realign, valid_out, data_out
   );

   modport slave (
      input  rx_data, rx_strobe, rx_err,
      output deser_realign, valid_out, data_out
   );
endinterface

// File: rtl/rx_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Single-cycle update; the counter holds at all-ones instead of wrapping.
module rx_sat_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {WIDTH{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive link controller: hunts COM symbols, locks, forwards payload, drops lock on errors.
// All outputs registered, one clk_4f after the strobe; no downstream backpressure.
module rx_link_ctrl
   import rx_link_pkg::*;
#(
   parameter int unsigned LOCK_COUNT     = 4,
   parameter int unsigned LOSS_COUNT     = 2,
   parameter int unsigned SEARCH_TIMEOUT = 16
) (
   input  logic           clk_4f,
   input  logic           reset,
   input  logic           enable,
   rx_link_ctrl_if.slave  link,
   output logic           link_active,
   output logic [2:0]     state_out,
   output logic [7:0]     lock_loss_cnt
);

   localparam logic [4:0] LOCK_C  = 5'(LOCK_COUNT);
   localparam logic [4:0] LOSS_C  = 5'(LOSS_COUNT);
   localparam logic [7:0] TO_LAST = 8'(SEARCH_TIMEOUT - 1);

   state_e     state, next_state;
   logic [3:0] com_cnt, err_cnt;
   logic [7:0] to_cnt;

   logic       com_clr, com_inc, err_clr, err_inc, to_clr, to_inc, loss_inc;
   logic       realign_nxt, vld_nxt;
   logic [7:0] dat_nxt;
   logic       realign_q, vld_q;
   logic [7:0] dat_q;
   logic       clean_com;

   assign clean_com = link.rx_strobe && !link.rx_err && (link.rx_data == COM_SYM);

   always_comb begin
      next_state  = state;
      com_clr     = 1'b0;
      com_inc     = 1'b0;
      err_clr     = 1'b0;
      err_inc     = 1'b0;
      to_clr      = 1'b0;
      to_inc      = 1'b0;
      loss_inc    = 1'b0;
      realign_nxt = 1'b0;
      vld_nxt     = 1'b0;
      dat_nxt     = dat_q;

      if (!enable) begin
         next_state = ST_DISABLED;
         com_clr    = 1'b1;
         err_clr    = 1'b1;
         to_clr     = 1'b1;
      end else begin
         case (state)
            ST_DISABLED: begin
               next_state = ST_SEARCH;
               com_clr    = 1'b1;
               err_clr    = 1'b1;
               to_clr     = 1'b1;
            end
            ST_SEARCH: begin
               if (link.rx_strobe) begin
                  if (clean_com) begin
                     to_clr = 1'b1;
                     if (LOCK_C == 5'd1) begin
                        next_state = ST_ACTIVE;
                        com_clr    = 1'b1;
                     end else begin
                        next_state = ST_LOCKING;
                        com_inc    = 1'b1;
                     end
                  end else if (to_cnt == TO_LAST) begin
                     realign_nxt = 1'b1;
                     to_clr      = 1'b1;
                  end else begin
                     to_inc = 1'b1;
                  end
               end
            end
            ST_LOCKING: begin
               if (link.rx_strobe) begin
                  if (clean_com) begin
                     if (({1'b0, com_cnt} + 5'd1) == LOCK_C) begin
                        next_state = ST_ACTIVE;
                        com_clr    = 1'b1;
                     end else begin
                        com_inc = 1'b1;
                     end
                  end else begin
                     next_state = ST_SEARCH;
                     com_clr    = 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (link.rx_strobe) begin
                  if (link.rx_err) begin
                     if (({1'b0, err_cnt} + 5'd1) == LOSS_C) begin
                        next_state  = ST_RECOVER;
                        err_clr     = 1'b1;
                        loss_inc    = 1'b1;
                        realign_nxt = 1'b1;
                     end else begin
                        err_inc = 1'b1;
                     end
                  end else begin
                     err_clr = 1'b1;
                     if ((link.rx_data != COM_SYM) && (link.rx_data != IDL_SYM)) begin
                        vld_nxt = 1'b1;
                        dat_nxt = link.rx_data;
                     end
                  end
               end
            end
            ST_RECOVER: begin
               // Strobes landing here are dropped; search restarts clean.
               next_state = ST_SEARCH;
               com_clr    = 1'b1;
               err_clr    = 1'b1;
               to_clr     = 1'b1;
            end
            default: begin
               next_state = ST_DISABLED;
               com_clr    = 1'b1;
               err_clr    = 1'b1;
               to_clr     = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state       <= ST_DISABLED;
         realign_q   <= 1'b0;
         vld_q       <= 1'b0;
         dat_q       <= 8'h00;
         link_active <= 1'b0;
      end else begin
         state       <= next_state;
         realign_q   <= realign_nxt;
         vld_q       <= vld_nxt;
         dat_q       <= dat_nxt;
         link_active <= (next_state == ST_ACTIVE);
      end
   end

   rx_sat_counter #(.WIDTH(4)) u_com_cnt (
      .clk(clk_4f), .rst_n(reset), .clr(com_clr), .inc(com_inc), .cnt(com_cnt)
   );

   rx_sat_counter #(.WIDTH(4)) u_err_cnt (
      .clk(clk_4f), .rst_n(reset), .clr(err_clr), .inc(err_inc), .cnt(err_cnt)
   );

   rx_sat_counter #(.WIDTH(8)) u_to_cnt (
      .clk(clk_4f), .rst_n(reset), .clr(to_clr), .inc(to_inc), .cnt(to_cnt)
   );

   rx_sat_counter #(.WIDTH(8)) u_loss_cnt (
      .clk(clk_4f), .rst_n(reset), .clr(1'b0), .inc(loss_inc), .cnt(lock_loss_cnt)
   );

   assign state_out          = state;
   assign link.deser_realign = realign_q;
   assign link.valid_out     = vld_q;
   assign link.data_out      = dat_q;

endmodule
